data_memory_responder: RTL
==========================

# data_memory_responder

Data-memory responder that serves load/store requests issued by the multicycle control unit during its memory-operation state. It accepts one request at a time over a req/ready handshake, performs a word or byte access into an internal word array after a fixed latency, and returns read data with a one-cycle done strobe. It sits between the control unit/ALU result (address) and the register-file write-back path, and is the responder counterpart to the control unit's memory-access step.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; legal byte addresses are 0 to 4*DEPTH_WORDS-1.
- `LATENCY`, default 2: edges from request acceptance to `mem_done` rising; legal range 1 to 15.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_req`  in  1  request valid.
- `mem_write`  in  1  1 = store, 0 = load.
- `mem_byte`  in  1  1 = byte access (LDRB/STRB), 0 = word access.
- `mem_addr`  in  32  byte address.
- `mem_wr_data`  in  32  store data; byte stores use bits [7:0].
- `mem_ready`  out  1  high only in IDLE; request accepted on an edge where `mem_req` and `mem_ready` are both 1.
- `mem_done`  out  1  one-cycle completion strobe.
- `mem_rd_data`  out  32  load result; updated only when `mem_done` rises, held otherwise.
- `mem_fault`  out  1  access error; meaningful only while `mem_done`=1, else 0.

## Operation
- States:
  - IDLE: `mem_ready`=1. On accept, latch addr/write/byte/wr_data, load counter with LATENCY-1, go to WAIT.
  - WAIT: inputs ignored. Counter==0 → perform access, go to RESPOND; otherwise decrement.
  - RESPOND: `mem_done`=1 for this cycle only; next edge → IDLE.
- Access is performed on the WAIT→RESPOND edge. Word index is addr[31:2]; byte lane is addr[1:0], little-endian (lane 0 = bits [7:0]).
- Fault conditions:
  - word index ≥ DEPTH_WORDS;
  - word access (`mem_byte`=0) with addr[1:0]≠0.
  - On fault: no write, `mem_rd_data`=0, `mem_fault`=1 during done.
- Word load: `mem_rd_data` = word.
- Byte load: `mem_rd_data` = selected byte, zero-extended.
- Word store: write all 32 bits.
- Byte store: write `mem_wr_data[7:0]` into the selected lane only; the other lanes are unchanged.
- On any store, `mem_rd_data` = 0.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset (async assert, any state): state=IDLE, `mem_ready`=1, `mem_done`=0, `mem_fault`=0, `mem_rd_data`=0, counter=0.
  - An in-flight request is aborted. If reset arrives before the WAIT→RESPOND edge, the store is not performed and the array is unchanged.
- Accept at edge N: `mem_ready` falls after N.
- `mem_done`, `mem_rd_data` and `mem_fault` are valid after edge N+LATENCY.
- `mem_done` falls and `mem_ready` rises after edge N+LATENCY+1.
- Earliest next accept is edge N+LATENCY+2. With `mem_req` held high, one request is accepted every LATENCY+2 cycles.
- `mem_req` dropping, or any input changing, during WAIT/RESPOND has no effect.
- No back-pressure on `mem_done`; the requester must sample it in its one-cycle window.

## Test plan
- Reset: hold `reset_n`=0 mid-clock → immediately `mem_ready`=1, `mem_done`=0, `mem_fault`=0, `mem_rd_data`=0x00000000.
- Word store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10, accepted at edge N → `mem_done`=1 only in the cycle after N+2, with `mem_rd_data`=0.
  - Load from 0x10 → `mem_rd_data`=0xDEADBEEF, `mem_fault`=0, `mem_ready` back after N+3.
- Byte access:
  - STRB 0x5A to 0x11, then word load from 0x10 → 0xDEAD5AEF.
  - LDRB from 0x13 → 0x000000DE.
- Faults:
  - Word load from 0x12 → `mem_fault`=1, `mem_rd_data`=0.
  - Word store 0x11111111 to 0x400 (DEPTH_WORDS=256) → `mem_fault`=1.
  - Then word load from 0x000 (previously 0xCAFEF00D) → 0xCAFEF00D, showing no wrap-around write occurred.
- Reset mid-operation:
  - Store 0x0 to 0x20.
  - Issue a store of 0x12345678 to 0x20 and pulse `reset_n` low during WAIT → no `mem_done` pulse.
  - Load from 0x20 → 0x00000000.
- Continuous request:
  - `mem_req` held high, address changed during WAIT → the latched address is used.
  - Accepts are spaced exactly LATENCY+2 edges apart (4 edges at LATENCY=2; 3 edges at LATENCY=1).

Source files
------------

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : Load/store responder for the multicycle control unit's memory
//            step. Accepts one request at a time (req/ready), performs a
//            word or byte access into an internal word array after a fixed
//            latency, then pulses mem_done_o for one cycle with the result.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   mem_req_i        in   request valid (sampled only while ready)
//   mem_write_i      in   1 = store, 0 = load
//   mem_byte_i       in   1 = byte access, 0 = word access
//   mem_addr_i       in   byte address
//   mem_wr_data_i    in   store data (byte stores use [7:0])
//   mem_ready_o      out  high only in IDLE
//   mem_done_o       out  one-cycle completion strobe
//   mem_rd_data_o    out  load result, held between completions
//   mem_fault_o      out  access error, only ever high together with done
// ============================================================================
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_req_i,
    input  logic        mem_write_i,
    input  logic        mem_byte_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wr_data_i,
    output logic        mem_ready_o,
    output logic        mem_done_o,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_fault_o
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  C_LAT_M1 = 4'(LATENCY - 1);
    localparam logic [31:0] C_DEPTH  = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        write_q;
    logic        byte_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_data_q;
    logic        fault_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        w_accept;
    logic        w_access;
    logic [29:0] w_idx;
    logic [1:0]  w_lane;
    logic [AW-1:0] w_mem_idx;
    logic        w_fault;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wr_word;
    logic [31:0] w_rd_word;
    logic [7:0]  w_rd_byte;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        w_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req_i) begin
                    w_accept = 1'b1;
                    cnt_d    = C_LAT_M1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter was loaded with LATENCY-1 at accept, so reaching
                // zero here lands the RESPOND edge exactly LATENCY edges later.
                if (cnt_q == 4'd0) begin
                    w_access = 1'b1;
                    state_d  = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode and access datapath (operates on latched request)
    // ------------------------------------------------------------------
    always_comb begin
        w_idx     = addr_q[31:2];
        w_lane    = addr_q[1:0];
        w_mem_idx = w_idx[AW-1:0];
        // Full 30-bit index is compared so high address bits can never
        // alias onto a legal word.
        w_fault   = ({2'b00, w_idx} >= C_DEPTH) || (!byte_q && (w_lane != 2'b00));
        w_we      = w_access && write_q && !w_fault;
        w_be      = byte_q ? (4'b0001 << w_lane) : 4'b1111;
        w_wr_word = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
        w_rd_word = w_fault ? 32'd0 : mem_q[w_mem_idx];
        w_rd_byte = 8'(w_rd_word >> {w_lane, 3'b000});
        if (w_fault || write_q) begin
            w_load_data = 32'd0;
        end else if (byte_q) begin
            w_load_data = {24'd0, w_rd_byte};
        end else begin
            w_load_data = w_rd_word;
        end
    end

    // ------------------------------------------------------------------
    // Control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            write_q   <= 1'b0;
            byte_q    <= 1'b0;
            wdata_q   <= 32'd0;
            rd_data_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                addr_q  <= mem_addr_i;
                write_q <= mem_write_i;
                byte_q  <= mem_byte_i;
                wdata_q <= mem_wr_data_i;
            end
            if (w_access) begin
                rd_data_q <= w_load_data;
                fault_q   <= w_fault;
            end else if (state_q == S_RESPOND) begin
                fault_q   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array: deliberately not reset. Reset already forces state_q
    // to IDLE, which removes the write enable for an aborted store.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    mem_q[w_mem_idx][8*l +: 8] <= w_wr_word[8*l +: 8];
                end
            end
        end
    end

    assign mem_ready_o   = (state_q == S_IDLE);
    assign mem_done_o    = (state_q == S_RESPOND);
    assign mem_rd_data_o = rd_data_q;
    assign mem_fault_o   = fault_q;

endmodule
`default_nettype wire
